uart_boot_rx: RTL
=================

# uart_boot_rx

Serial receive front end for the bootloader path. It samples the asynchronous `RX` line, deserialises 8N1 UART frames, and packs consecutive bytes little-endian into `BITS`-wide words. It buffers those words in a small first-word-fall-through FIFO and hands them downstream through a valid/ready handshake. It sits between the board `RX` pin and the boot word sequencer, which assigns addresses and destinations (`dst`) and drives CPU/coprocessor memory writes.

## Interface
- `BAUD_DIV`, 434, clock cycles per UART bit (≥ 8; 50 MHz / 115200).
- `BITS`, 32, output word width; must be a multiple of 8.
- `FIFO_DEPTH`, 4, word FIFO entries; a power of 2, ≥ 2.
- `clk`  in  1  system clock (PLL `outclk_0` domain).
- `rst`  in  1  synchronous, active-high reset.
- `RX`  in  1  asynchronous UART line, idle high.
- `flush`  in  1  single-cycle; discards the partial word and all FIFO contents.
- `clr_err`  in  1  clears the sticky error flags.
- `word_rdy`  in  1  downstream accepts `word_data` this cycle.
- `word_vld`  out  1  FIFO non-empty; `word_data` is valid.
- `word_data`  out  BITS  FIFO head word.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overflow`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `rx_busy`  out  1  receive FSM is not in IDLE.

## Operation
- **RX synchroniser:** 2 flops; both reset to 1. All FSM decisions use the second flop, `rx_s`.
- **Bit counter:** `bit_cnt` is a down-counter. A "tick" is the cycle in which it equals 0.
- **Receive FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on `rx_s==0`, go to START and load `bit_cnt = BAUD_DIV/2 - 1`.
  - START: at the tick, if `rx_s==1` it is a false start; return to IDLE. Otherwise go to DATA with `bit_cnt = BAUD_DIV-1` and bit index 0.
  - DATA: at each tick, shift `rx_s` in LSB-first and reload the counter. After bit 7, go to STOP.
  - STOP: at the tick, if `rx_s==1` the byte is done; go to IDLE. If `rx_s==0`, set `frame_err`, discard the byte, reset `byte_idx` to 0 (partial word dropped), and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. Holding a break low never produces bytes.
- **Packer:**
  - A done byte is written into lane `byte_idx` of the assembly register; the first byte goes to `[7:0]`.
  - `byte_idx` increments and wraps at `BITS/8`.
  - On the last lane, the assembled word (including the current byte) is pushed to the FIFO.
- **FIFO:**
  - Pop when `word_vld && word_rdy`.
  - Push while full with no pop: the word is dropped and `overflow` is set. `byte_idx` still wraps to 0.
  - Push and pop in the same cycle when full: both occur and `overflow` is not set.
  - Push and pop when empty: the word enters the FIFO. `word_vld` rises the next cycle, because a pop needs `word_vld`.
- **`flush`:**
  - Empties the FIFO, clears `byte_idx` and the assembly register.
  - Does not affect the FSM, so a frame in flight completes and lands in lane 0.
  - A push in the same cycle as `flush` is discarded.
- **Sticky flags:**
  - `clr_err` clears `frame_err` and `overflow`.
  - If a set and `clr_err` occur in the same cycle, the set wins.

## Timing
- **Reset values:**
  - Outputs: `word_vld=0`, `word_data=0`, `frame_err=0`, `overflow=0`, `rx_busy=0`.
  - Internal: FSM in IDLE, `byte_idx=0`, FIFO empty.
- **Latency:**
  - A falling edge on `RX` reaches `rx_s` 2 cycles later.
  - Start-bit centre is sampled `BAUD_DIV/2` cycles after FSM entry to START.
  - Data bit k is sampled `(k+1)*BAUD_DIV` cycles after that; the stop bit `9*BAUD_DIV` cycles after it.
- **Word output:** the last byte's stop sample and the FIFO push occur at the same clock edge. `word_vld` is high in the next cycle, with `word_data` already stable.
- **Output stability:** `word_data` changes only on a pop, on a push into an empty FIFO, or on `flush`. It holds while `word_vld && !word_rdy`.
- **`rx_busy`:** high from the cycle after IDLE exits until the cycle after return to IDLE.
- **Reset mid-frame:** `rst` returns everything to reset values on the next edge. The remaining bits of the interrupted frame are treated as line activity. The receiver must recover within one frame of idle-high line.

## Test plan
- **Reset:** `BAUD_DIV=16`; assert `rst` 2 cycles -> all outputs 0; `rx_busy=0` while `RX=1`.
- **Single word:** send bytes 0x01,0x02,0x03,0x04 with `word_rdy=1` -> exactly one `word_vld` pulse with `word_data=0x04030201`, one cycle after the 4th stop sample; `frame_err=0`.
- **False start:** drive a 6-cycle low glitch on `RX` (< `BAUD_DIV/2`) -> FSM returns to IDLE; no byte accepted; `word_vld` stays 0.
- **Framing error:**
  - Send 0xAA, 0xBB, then a frame with its stop bit low, held low 40 cycles -> `frame_err=1`; FSM holds in WAIT_HIGH.
  - Then send 0x11,0x22,0x33,0x44 -> `word_data=0x44332211`.
  - Then `clr_err` -> `frame_err=0`.
- **Overflow:** `word_rdy=0`; send 5 words (20 bytes) -> `overflow=1`, 4 words retained in order. Raise `word_rdy` -> words 1–4 drain, word 5 absent.
- **Flush/reset mid-frame:**
  - Send 2 bytes, then pulse `flush` -> the next 4 bytes form a clean word.
  - Separately, assert `rst` during DATA -> reset values; next full word is correct.

Source files
------------

// File: rtl/uart_boot_rx.sv
// uart_boot_rx
// Boot-path serial receiver. It synchronises the asynchronous RX pin and
// deserialises 8N1 frames. Consecutive bytes are packed little-endian into
// BITS-wide words, which are queued in a small first-word-fall-through FIFO.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   RX         asynchronous UART line, idle high
//   flush      one-cycle pulse: drop the partial word and all queued words
//   clr_err    clears the sticky frame_err / overflow flags
//   word_rdy   downstream accepts word_data this cycle
//   word_vld   FIFO non-empty, word_data valid
//   word_data  FIFO head word
//   frame_err  sticky: a stop bit was sampled low
//   overflow   sticky: a completed word was dropped on a full FIFO
//   rx_busy    receive FSM is not idle
module uart_boot_rx #(
    parameter int BAUD_DIV   = 434,
    parameter int BITS       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RX,
    input  logic            flush,
    input  logic            clr_err,
    input  logic            word_rdy,
    output logic            word_vld,
    output logic [BITS-1:0] word_data,
    output logic            frame_err,
    output logic            overflow,
    output logic            rx_busy
);

    localparam int CNT_W  = $clog2(BAUD_DIV);
    localparam int LANES  = BITS / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [AW:0]       PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // RX synchroniser; both stages reset to the idle level so a reset
    // never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_s_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       rx_byte_reg, rx_byte_next;
    logic             byte_done;
    logic             frame_bad;
    logic             tick;

    assign tick = (bit_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            rx_byte_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            rx_byte_reg <= rx_byte_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        rx_byte_next = rx_byte_reg;
        byte_done    = 1'b0;
        frame_bad    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rx_s_reg) begin
                    state_next   = S_START;
                    bit_cnt_next = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s_reg) begin
                        // line went back high before mid-bit: glitch
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA;
                        bit_cnt_next = FULL_LOAD;
                        bit_idx_next = '0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - CNT_ONE;
                end
            end
            S_DATA: begin
                if (tick) begin
                    rx_byte_next = {rx_s_reg, rx_byte_reg[7:1]};
                    bit_cnt_next = FULL_LOAD;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - CNT_ONE;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s_reg) begin
                        byte_done  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                // a held break must not be mistaken for a new start bit
                if (rx_s_reg) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rx_busy = (state_reg != S_IDLE);

    // ------------------------------------------------------------------
    // Byte packer. asm_next is the assembly register with the incoming
    // byte already merged, so the pushed word includes the final byte.
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] byte_idx_reg;
    logic [BITS-1:0]   asm_reg;
    logic [BITS-1:0]   asm_next;
    logic              last_lane;
    logic              push_req;

    assign last_lane = (byte_idx_reg == LAST_LANE);
    assign push_req  = byte_done && last_lane && !flush;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign asm_next[gi*8 +: 8] = (byte_done && byte_idx_reg == LANE_W'(gi))
                                   ? rx_byte_reg : asm_reg[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            byte_idx_reg <= '0;
            asm_reg      <= '0;
        end else begin
            asm_reg <= asm_next;
            if (frame_bad) begin
                byte_idx_reg <= '0;
            end else if (byte_done) begin
                byte_idx_reg <= last_lane ? '0 : byte_idx_reg + LANE_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO (first-word-fall-through). Pointers carry one extra bit
    // to tell full from empty.
    // ------------------------------------------------------------------
    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic [BITS-1:0]       mem_reg [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_we;
    logic                  empty, full, pop, push_ok, push_drop;

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign word_vld  = !empty;
    assign pop       = word_vld && word_rdy;
    // a pop in the same cycle frees the slot the push lands in
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
        assign mem_we[gi] = push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (mem_we[i]) begin
                    mem_reg[i] <= asm_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    assign word_data = mem_reg[rd_ptr_reg[AW-1:0]];

    // ------------------------------------------------------------------
    // Sticky error flags; a new event wins over a simultaneous clear.
    // ------------------------------------------------------------------
    logic frame_err_reg;
    logic overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (frame_bad) begin
                frame_err_reg <= 1'b1;
            end else if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule
